ila_capture_ctrl: RTL

Capture sequencer for the ILA sample buffer.
- Arms on software command and fills a configurable pre-trigger window.
- Qualifies the masked, negated, level/edge trigger vector and counts post-trigger samples.
- Drives write enable and write address of the circular sample buffer, then reports where the captured window starts.
- Sits between the register file and the ila_core sample RAM, in the system clock domain. sample_en arrives already synchronised.

---
 rtl/ila_capture_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/ila_capture_ctrl.sv
// ila_capture_ctrl: ILA capture sequencer (pre-trigger fill, trigger qualify, post-trigger count).
// Optional trigger holdoff counter enabled by defining ILA_TRIG_HOLDOFF_EN.
module ila_capture_ctrl #(
  parameter int BUFFER_W  = 10,
  parameter int TRIGGER_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arm,
  input  logic                 abort,
  input  logic                 force_trig,
  input  logic                 sample_en,
  input  logic [TRIGGER_W-1:0] trigger,
  input  logic [TRIGGER_W-1:0] trigger_mask,
  input  logic [TRIGGER_W-1:0] trigger_negate,
  input  logic [TRIGGER_W-1:0] trigger_type,
  input  logic                 trigger_all,
  input  logic [BUFFER_W-1:0]  pre_depth,
  input  logic [BUFFER_W-1:0]  post_depth,
`ifdef ILA_TRIG_HOLDOFF_EN
  input  logic [7:0]           trig_holdoff,
`endif
  output logic                 buf_wr_en,
  output logic [BUFFER_W-1:0]  buf_wr_addr,
  output logic [BUFFER_W-1:0]  start_addr,
  output logic [BUFFER_W:0]    n_samples,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err
);
  typedef enum logic [2:0] {IDLE, PRE, WAIT, POST, DONE} state_t;
  state_t                state;
  logic [BUFFER_W-1:0]   wr_addr, pre_cnt, post_cnt, trig_addr, pre_q, post_q;
  logic [TRIGGER_W-1:0]  mask_q, neg_q, type_q, prev_q, q, e;
  logic                  all_q, force_pend, hit, hit_fire, fire, wr, cfg_bad;
  logic [BUFFER_W+1:0]   total;
  logic [BUFFER_W:0]     n_total;
  assign q = trigger ^ neg_q;
  assign e = (q & ~prev_q & type_q) | (q & ~type_q);
  // AND mode needs a non-empty mask, otherwise an all-disabled vector would fire
  assign hit = all_q ? (&(e | ~mask_q) && |mask_q) : |(e & mask_q);
  assign total = {2'b0, pre_depth} + {2'b0, post_depth} + (BUFFER_W+2)'(1);
  assign cfg_bad = total > (BUFFER_W+2)'(2**BUFFER_W);
  assign n_total = {1'b0, pre_q} + {1'b0, post_q} + (BUFFER_W+1)'(1);
  assign wr = sample_en & busy;
  assign buf_wr_en = wr;
  assign buf_wr_addr = wr_addr;
`ifdef ILA_TRIG_HOLDOFF_EN
  logic [7:0] hold_q, hit_cnt;
  assign hit_fire = hit && hit_cnt == hold_q;
`else
  assign hit_fire = hit;
`endif
  assign fire = state == WAIT && sample_en && (hit_fire || force_trig || force_pend);
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      wr_addr <= '0;
      pre_cnt <= '0;
      post_cnt <= '0;
      trig_addr <= '0;
      prev_q <= '0;
      pre_q <= '0;
      post_q <= '0;
      mask_q <= '0;
      neg_q <= '0;
      type_q <= '0;
      all_q <= 1'b0;
      force_pend <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      cfg_err <= 1'b0;
      start_addr <= '0;
      n_samples <= '0;
`ifdef ILA_TRIG_HOLDOFF_EN
      hold_q <= '0;
      hit_cnt <= '0;
`endif
    end else begin
      if (sample_en) prev_q <= q;
      if (abort) begin
        state <= IDLE;
        busy <= 1'b0;
        done <= 1'b0;
        cfg_err <= 1'b0;
        force_pend <= 1'b0;
        start_addr <= '0;
        n_samples <= '0;
      end else begin
        cfg_err <= 1'b0;
        if (wr) wr_addr <= wr_addr + 1'b1;
        case (state)
          IDLE, DONE: if (arm) begin
            if (cfg_bad) cfg_err <= 1'b1;
            else begin
              pre_q <= pre_depth;
              post_q <= post_depth;
              mask_q <= trigger_mask;
              neg_q <= trigger_negate;
              type_q <= trigger_type;
              all_q <= trigger_all;
              wr_addr <= '0;
              pre_cnt <= '0;
              post_cnt <= '0;
              trig_addr <= '0;
              force_pend <= 1'b0;
              start_addr <= '0;
              n_samples <= '0;
              done <= 1'b0;
              busy <= 1'b1;
              state <= pre_depth == '0 ? WAIT : PRE;
`ifdef ILA_TRIG_HOLDOFF_EN
              hold_q <= trig_holdoff;
              hit_cnt <= '0;
`endif
            end
          end
          PRE: if (wr) begin
            pre_cnt <= pre_cnt + 1'b1;
            if (pre_cnt + 1'b1 == pre_q) state <= WAIT;
          end
          WAIT: if (fire) begin
            trig_addr <= wr_addr;
            force_pend <= 1'b0;
            if (post_q == '0) begin
              state <= DONE;
              busy <= 1'b0;
              done <= 1'b1;
              start_addr <= wr_addr - pre_q;
              n_samples <= n_total;
            end else state <= POST;
          end else begin
            if (force_trig) force_pend <= 1'b1;
`ifdef ILA_TRIG_HOLDOFF_EN
            if (sample_en && hit) hit_cnt <= hit_cnt + 1'b1;
`endif
          end
          POST: if (wr) begin
            post_cnt <= post_cnt + 1'b1;
            if (post_cnt + 1'b1 == post_q) begin
              state <= DONE;
              busy <= 1'b0;
              done <= 1'b1;
              start_addr <= trig_addr - pre_q;
              n_samples <= n_total;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
